// File: rtl/lsq_unit.sv
// Load/store unit: circular store queue with in-order commit/drain, store-to-load
// forwarding, branch-mask kill with tail rollback, and one shared data-cache port.
module lsq_unit #(
    parameter int unsigned WIDTH_REG = 5,
    parameter int unsigned WIDTH_TAG = 4,
    parameter int unsigned WIDTH_BRM = 4,
    parameter int unsigned WIDTH_MEM = 8,
    parameter int unsigned DEPTH_SQ  = 8,
    parameter int unsigned XLEN      = 32
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_val,
    input  logic                              i_store,
    input  logic [XLEN-1:0]                   i_op1,
    input  logic [XLEN-1:0]                   i_imm,
    input  logic [XLEN-1:0]                   i_op2,
    input  logic [WIDTH_REG-1:0]              i_rd,
    input  logic [WIDTH_TAG-1:0]              i_tag,
    input  logic [WIDTH_BRM-1:0]              i_brmask,
    output logic                              o_ready,
    input  logic [WIDTH_BRM-1:0]              i_brkill,
    input  logic                              i_commit,
    output logic                              o_dc_req,
    output logic                              o_dc_we,
    output logic [WIDTH_MEM-1:0]              o_dc_addr,
    output logic [XLEN-1:0]                   o_dc_data,
    input  logic                              i_dc_ack,
    input  logic [XLEN-1:0]                   i_dc_data,
    output logic                              o_wb_val,
    output logic [WIDTH_REG-1:0]              o_wb_rd,
    output logic [WIDTH_TAG-1:0]              o_wb_tag,
    output logic [XLEN-1:0]                   o_wb_data,
    output logic [$clog2(DEPTH_SQ):0]         o_sq_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH_SQ);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {D_IDLE, D_ST, D_LD} dstate_t;

    dstate_t state, state_next;

    // store queue storage
    logic [WIDTH_MEM-1:0] sq_addr      [DEPTH_SQ];
    logic [XLEN-1:0]      sq_data      [DEPTH_SQ];
    logic [WIDTH_BRM-1:0] sq_brmask    [DEPTH_SQ];
    logic                 sq_committed [DEPTH_SQ];

    logic [PTR_W-1:0] head;
    logic [CNT_W-1:0] count, ccnt;

    // load buffer
    logic                 lb_pending, lb_dead;
    logic [WIDTH_MEM-1:0] lb_addr;
    logic [WIDTH_REG-1:0] lb_rd;
    logic [WIDTH_TAG-1:0] lb_tag;
    logic [WIDTH_BRM-1:0] lb_brmask;

    logic [WIDTH_MEM-1:0] addr_c;
    logic                 issue_ok_c, st_alloc_c, ld_acc_c;
    logic                 commit_do_c, pop_c, lb_kill_c, head_cmt_c;
    logic                 fwd_hit_c;
    logic [XLEN-1:0]      fwd_data_c;
    logic [CNT_W-1:0]     ccnt_cm_c, survivors_c, count_next_c, ccnt_next_c;
    logic [PTR_W-1:0]     wr_ptr_c, commit_ptr_c;
    logic                 lb_pending_next_c;
    logic                 req_next_c, we_next_c;
    logic [WIDTH_MEM-1:0] addr_next_c;
    logic [XLEN-1:0]      data_next_c;

    assign addr_c       = WIDTH_MEM'(i_op1 + i_imm);
    assign issue_ok_c   = i_val && o_ready && ((i_brmask & i_brkill) == '0);
    assign st_alloc_c   = issue_ok_c && i_store;
    assign ld_acc_c     = issue_ok_c && !i_store;
    assign commit_do_c  = i_commit && (ccnt < count);
    assign pop_c        = (state == D_ST) && i_dc_ack;
    assign lb_kill_c    = lb_pending && ((lb_brmask & i_brkill) != '0);
    assign head_cmt_c   = (count != '0) && sq_committed[head];
    assign ccnt_cm_c    = ccnt + CNT_W'(commit_do_c);
    assign commit_ptr_c = head + PTR_W'(ccnt);
    assign wr_ptr_c     = head + PTR_W'(survivors_c);
    assign count_next_c = survivors_c - CNT_W'(pop_c) + CNT_W'(st_alloc_c);
    assign ccnt_next_c  = ccnt_cm_c - CNT_W'(pop_c);
    assign o_sq_count   = count;

    // youngest matching entry wins; search sees pre-edge contents
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        for (int i = 0; i < int'(DEPTH_SQ); i++) begin
            if ((CNT_W'(i) < count) && (sq_addr[head + PTR_W'(i)] == addr_c)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = sq_data[head + PTR_W'(i)];
            end
        end
    end

    // entries surviving a branch kill; the entry committing this cycle is safe
    always_comb begin
        survivors_c = '0;
        for (int i = 0; i < int'(DEPTH_SQ); i++) begin
            if ((CNT_W'(i) < count) &&
                !((CNT_W'(i) >= ccnt_cm_c) &&
                  ((sq_brmask[head + PTR_W'(i)] & i_brkill) != '0)))
                survivors_c = survivors_c + CNT_W'(1);
        end
    end

    always_comb begin
        lb_pending_next_c = lb_pending;
        if (ld_acc_c && !fwd_hit_c)
            lb_pending_next_c = 1'b1;
        else if (lb_pending) begin
            if (state == D_LD) begin
                if (i_dc_ack)
                    lb_pending_next_c = 1'b0;
            end else if (lb_kill_c) begin
                lb_pending_next_c = 1'b0;
            end
        end
    end

    // cache FSM: next state and registered request fields
    always_comb begin
        state_next  = state;
        req_next_c  = o_dc_req;
        we_next_c   = o_dc_we;
        addr_next_c = o_dc_addr;
        data_next_c = o_dc_data;
        case (state)
            D_IDLE: begin
                if (lb_pending && !lb_kill_c) begin
                    state_next  = D_LD;
                    req_next_c  = 1'b1;
                    we_next_c   = 1'b0;
                    addr_next_c = lb_addr;
                    data_next_c = '0;
                end else if (head_cmt_c) begin
                    state_next  = D_ST;
                    req_next_c  = 1'b1;
                    we_next_c   = 1'b1;
                    addr_next_c = sq_addr[head];
                    data_next_c = sq_data[head];
                end
            end
            D_ST, D_LD: begin
                if (i_dc_ack) begin
                    state_next  = D_IDLE;
                    req_next_c  = 1'b0;
                    we_next_c   = 1'b0;
                    addr_next_c = '0;
                    data_next_c = '0;
                end
            end
            default: begin
                state_next  = D_IDLE;
                req_next_c  = 1'b0;
                we_next_c   = 1'b0;
                addr_next_c = '0;
                data_next_c = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= D_IDLE;
            o_dc_req  <= 1'b0;
            o_dc_we   <= 1'b0;
            o_dc_addr <= '0;
            o_dc_data <= '0;
        end else begin
            state     <= state_next;
            o_dc_req  <= req_next_c;
            o_dc_we   <= we_next_c;
            o_dc_addr <= addr_next_c;
            o_dc_data <= data_next_c;
        end
    end

    // queue pointers, commit state and branch masks
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head  <= '0;
            count <= '0;
            ccnt  <= '0;
            for (int i = 0; i < int'(DEPTH_SQ); i++) begin
                sq_committed[i] <= 1'b0;
                sq_brmask[i]    <= '0;
            end
        end else begin
            head  <= head + PTR_W'(pop_c);
            count <= count_next_c;
            ccnt  <= ccnt_next_c;
            if (commit_do_c) begin
                sq_committed[commit_ptr_c] <= 1'b1;
                sq_brmask[commit_ptr_c]    <= '0;
            end
            if (st_alloc_c) begin
                sq_committed[wr_ptr_c] <= 1'b0;
                sq_brmask[wr_ptr_c]    <= i_brmask;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (st_alloc_c) begin
            sq_addr[wr_ptr_c] <= addr_c;
            sq_data[wr_ptr_c] <= i_op2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lb_pending <= 1'b0;
            lb_dead    <= 1'b0;
            lb_addr    <= '0;
            lb_rd      <= '0;
            lb_tag     <= '0;
            lb_brmask  <= '0;
            o_ready    <= 1'b1;
        end else begin
            lb_pending <= lb_pending_next_c;
            o_ready    <= !lb_pending_next_c && (count_next_c != CNT_W'(DEPTH_SQ));
            if (ld_acc_c && !fwd_hit_c) begin
                lb_dead   <= 1'b0;
                lb_addr   <= addr_c;
                lb_rd     <= i_rd;
                lb_tag    <= i_tag;
                lb_brmask <= i_brmask;
            end else if (lb_pending) begin
                lb_brmask <= lb_brmask & ~i_brkill;
                if ((state == D_LD) && lb_kill_c)
                    lb_dead <= 1'b1;
            end
        end
    end

    // register-file writeback: forwarded hit or completed live miss
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wb_val  <= 1'b0;
            o_wb_rd   <= '0;
            o_wb_tag  <= '0;
            o_wb_data <= '0;
        end else begin
            o_wb_val <= 1'b0;
            if (ld_acc_c && fwd_hit_c) begin
                o_wb_val  <= 1'b1;
                o_wb_rd   <= i_rd;
                o_wb_tag  <= i_tag;
                o_wb_data <= fwd_data_c;
            end else if ((state == D_LD) && i_dc_ack && !lb_dead && !lb_kill_c) begin
                o_wb_val  <= 1'b1;
                o_wb_rd   <= lb_rd;
                o_wb_tag  <= lb_tag;
                o_wb_data <= i_dc_data;
            end
        end
    end

endmodule

// File: tb/tb_lsq_unit.sv
// Directed bench for lsq_unit: forwarding, miss path, full/wrap drain order,
// branch kill rollback, load kill, and asynchronous reset mid-drain.
module tb_lsq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_val, i_store, i_commit, i_dc_ack;
    logic [31:0] i_op1, i_imm, i_op2, i_dc_data;
    logic [4:0]  i_rd;
    logic [3:0]  i_tag, i_brmask, i_brkill;
    logic        o_ready, o_dc_req, o_dc_we, o_wb_val;
    logic [7:0]  o_dc_addr;
    logic [31:0] o_dc_data, o_wb_data;
    logic [4:0]  o_wb_rd;
    logic [3:0]  o_wb_tag;
    logic [3:0]  o_sq_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsq_unit dut (
        .i_clk(clk), .i_rst(rst),
        .i_val(i_val), .i_store(i_store),
        .i_op1(i_op1), .i_imm(i_imm), .i_op2(i_op2),
        .i_rd(i_rd), .i_tag(i_tag), .i_brmask(i_brmask),
        .o_ready(o_ready), .i_brkill(i_brkill), .i_commit(i_commit),
        .o_dc_req(o_dc_req), .o_dc_we(o_dc_we), .o_dc_addr(o_dc_addr), .o_dc_data(o_dc_data),
        .i_dc_ack(i_dc_ack), .i_dc_data(i_dc_data),
        .o_wb_val(o_wb_val), .o_wb_rd(o_wb_rd), .o_wb_tag(o_wb_tag), .o_wb_data(o_wb_data),
        .o_sq_count(o_sq_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_val = 1'b0; i_store = 1'b0; i_commit = 1'b0; i_dc_ack = 1'b0;
        i_op1 = '0; i_imm = '0; i_op2 = '0; i_dc_data = '0;
        i_rd = '0; i_tag = '0; i_brmask = '0; i_brkill = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bm);
        i_val = 1'b1; i_store = 1'b1; i_op1 = a; i_imm = '0; i_op2 = d; i_brmask = bm;
    endtask

    task automatic drive_load(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                              input logic [3:0] tg, input logic [3:0] bm);
        i_val = 1'b1; i_store = 1'b0; i_op1 = a; i_imm = b; i_rd = rd; i_tag = tg; i_brmask = bm;
    endtask

    // wait (bounded) for a store request, check it, ack it for one cycle
    task automatic drain_expect(input string tag, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        while (o_dc_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(o_dc_req), 32'd1);
        chk({tag, "_we"}, 32'(o_dc_we), 32'd1);
        chk({tag, "_addr"}, 32'(o_dc_addr), 32'(a));
        chk({tag, "_data"}, o_dc_data, d);
        i_dc_ack = 1'b1;
        step();
        i_dc_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        do_reset();
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_count", 32'(o_sq_count), 32'd0);
        chk("rst_req", 32'(o_dc_req), 32'd0);
        chk("rst_wb", 32'(o_wb_val), 32'd0);

        // store/store/load same address (first store address wraps to 0x10), youngest forwards
        i_imm = 32'h20;
        drive_store(32'hF0, 32'h11111111, 4'h0);
        i_imm = 32'h20;
        step();
        chk("fwd_count1", 32'(o_sq_count), 32'd1);
        drive_store(32'h10, 32'hDEADBEEF, 4'h0);
        step();
        chk("fwd_count2", 32'(o_sq_count), 32'd2);
        drive_load(32'h08, 32'h08, 5'd7, 4'd9, 4'h0);
        step();
        i_val = 1'b0;
        chk("fwd_wbval", 32'(o_wb_val), 32'd1);
        chk("fwd_wbdata", o_wb_data, 32'hDEADBEEF);
        chk("fwd_wbrd", 32'(o_wb_rd), 32'd7);
        chk("fwd_wbtag", 32'(o_wb_tag), 32'd9);
        chk("fwd_noreq", 32'(o_dc_req), 32'd0);
        step();
        chk("fwd_wbpulse", 32'(o_wb_val), 32'd0);
        chk("fwd_noreq2", 32'(o_dc_req), 32'd0);

        // load miss with three-cycle cache response
        do_reset();
        drive_load(32'h20, 32'h0, 5'd3, 4'd5, 4'h0);
        step();
        i_val = 1'b0;
        chk("miss_ready", 32'(o_ready), 32'd0);
        chk("miss_noreq_yet", 32'(o_dc_req), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("miss_req", 32'(o_dc_req), 32'd1);
            chk("miss_we", 32'(o_dc_we), 32'd0);
            chk("miss_addr", 32'(o_dc_addr), 32'h20);
            chk("miss_ready_low", 32'(o_ready), 32'd0);
            chk("miss_no_wb", 32'(o_wb_val), 32'd0);
        end
        i_dc_ack = 1'b1; i_dc_data = 32'h1234;
        step();
        i_dc_ack = 1'b0;
        chk("miss_wbval", 32'(o_wb_val), 32'd1);
        chk("miss_wbdata", o_wb_data, 32'h1234);
        chk("miss_wbrd", 32'(o_wb_rd), 32'd3);
        chk("miss_wbtag", 32'(o_wb_tag), 32'd5);
        chk("miss_req_drop", 32'(o_dc_req), 32'd0);
        chk("miss_ready_back", 32'(o_ready), 32'd1);
        step();
        chk("miss_wbpulse", 32'(o_wb_val), 32'd0);

        // full queue, partial drain, wrap, in-order drain
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive_store(32'h40 + 32'(k), 32'h100 + 32'(k), 4'h0);
            step();
        end
        chk("full_count", 32'(o_sq_count), 32'd8);
        chk("full_ready", 32'(o_ready), 32'd0);
        drive_store(32'h99, 32'h999, 4'h0);
        step();
        i_val = 1'b0;
        chk("full_stall_count", 32'(o_sq_count), 32'd8);
        i_commit = 1'b1;
        repeat (3) step();
        i_commit = 1'b0;
        for (int k = 0; k < 3; k++)
            drain_expect("drain_a", 8'h40 + 8'(k), 32'h100 + 32'(k));
        chk("drain_count5", 32'(o_sq_count), 32'd5);
        chk("drain_ready", 32'(o_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive_store(32'h50 + 32'(k), 32'h200 + 32'(k), 4'h0);
            step();
        end
        i_val = 1'b0;
        chk("wrap_count8", 32'(o_sq_count), 32'd8);
        i_commit = 1'b1;
        repeat (8) step();
        i_commit = 1'b0;
        for (int k = 3; k < 8; k++)
            drain_expect("drain_b", 8'h40 + 8'(k), 32'h100 + 32'(k));
        for (int k = 0; k < 3; k++)
            drain_expect("drain_wrap", 8'h50 + 8'(k), 32'h200 + 32'(k));
        chk("wrap_empty", 32'(o_sq_count), 32'd0);

        // branch kill rolls the tail back past uncommitted entries
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_store(32'h60 + 32'(k), 32'h300 + 32'(k), 4'h1);
            step();
        end
        drive_store(32'h6F, 32'hBAD, 4'h2);
        i_brkill = 4'h2;
        step();
        i_val = 1'b0; i_brkill = 4'h0;
        chk("issue_kill_count", 32'(o_sq_count), 32'd4);
        i_commit = 1'b1;
        repeat (2) step();
        i_commit = 1'b0;
        i_brkill = 4'h1;
        step();
        i_brkill = 4'h0;
        chk("kill_count", 32'(o_sq_count), 32'd2);
        drive_store(32'h70, 32'h400, 4'h0);
        step();
        i_val = 1'b0;
        chk("kill_realloc_count", 32'(o_sq_count), 32'd3);
        i_commit = 1'b1;
        step();
        i_commit = 1'b0;
        drain_expect("kill_drain0", 8'h60, 32'h300);
        drain_expect("kill_drain1", 8'h61, 32'h301);
        drain_expect("kill_drain2", 8'h70, 32'h400);
        chk("kill_empty", 32'(o_sq_count), 32'd0);

        // kill of an outstanding load miss suppresses writeback
        do_reset();
        drive_load(32'h30, 32'h0, 5'd4, 4'd2, 4'h4);
        step();
        i_val = 1'b0;
        step();
        chk("ldkill_req", 32'(o_dc_req), 32'd1);
        chk("ldkill_addr", 32'(o_dc_addr), 32'h30);
        i_brkill = 4'h4;
        step();
        i_brkill = 4'h0;
        chk("ldkill_req_held", 32'(o_dc_req), 32'd1);
        i_dc_ack = 1'b1; i_dc_data = 32'h5555;
        step();
        i_dc_ack = 1'b0;
        chk("ldkill_no_wb", 32'(o_wb_val), 32'd0);
        chk("ldkill_req_drop", 32'(o_dc_req), 32'd0);
        chk("ldkill_ready", 32'(o_ready), 32'd1);
        step();
        chk("ldkill_no_wb2", 32'(o_wb_val), 32'd0);

        // kill of a captured load before it reaches the cache
        drive_load(32'h34, 32'h0, 5'd6, 4'd1, 4'h8);
        step();
        i_val = 1'b0;
        chk("idlekill_pending", 32'(o_ready), 32'd0);
        i_brkill = 4'h8;
        step();
        i_brkill = 4'h0;
        chk("idlekill_noreq", 32'(o_dc_req), 32'd0);
        chk("idlekill_ready", 32'(o_ready), 32'd1);
        step();
        chk("idlekill_noreq2", 32'(o_dc_req), 32'd0);
        chk("idlekill_no_wb", 32'(o_wb_val), 32'd0);

        // asynchronous reset while a store drain is outstanding
        do_reset();
        drive_store(32'h44, 32'hABCD, 4'h0);
        step();
        i_val = 1'b0;
        i_commit = 1'b1;
        step();
        i_commit = 1'b0;
        step();
        chk("rstd_req", 32'(o_dc_req), 32'd1);
        chk("rstd_addr", 32'(o_dc_addr), 32'h44);
        #2;
        rst = 1'b1;
        #1;
        chk("rstd_req_drop", 32'(o_dc_req), 32'd0);
        chk("rstd_count", 32'(o_sq_count), 32'd0);
        chk("rstd_ready", 32'(o_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        chk("rstd_idle", 32'(o_dc_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsq_unit.md
# lsq_unit

Parametrised load/store unit that replaces the fixed single-entry address/queue path with a circular store queue of configurable depth. It provides in-order store commit and drain to the data cache, store-to-load forwarding, branch-mask kill with tail rollback, and a single arbitrated data-cache port shared by store drains and load misses. It sits between the memory issue slot and the data cache, and writes load results back to the register file.

## Interface

- WIDTH_REG, 5: destination register index width
- WIDTH_TAG, 4: ROB tag width
- WIDTH_BRM, 4: branch mask width; one bit per in-flight branch
- WIDTH_MEM, 8: word address width of the data cache
- DEPTH_SQ, 8: store queue entries; power of two, at least 2
- XLEN, 32: data width

Ports:

- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_val  in  1  issue valid
- i_store  in  1  1 = store, 0 = load
- i_op1, i_imm, i_op2  in  XLEN each  base, offset, store data
- i_rd  in  WIDTH_REG  load destination
- i_tag  in  WIDTH_TAG  ROB tag
- i_brmask  in  WIDTH_BRM  branches this op depends on
- o_ready  out  1  issue accepted when i_val & o_ready
- i_brkill  in  WIDTH_BRM  mispredicted-branch bits, single-cycle pulse
- i_commit  in  1  ROB commits the oldest uncommitted store
- o_dc_req, o_dc_we  out  1 each  cache request, write enable
- o_dc_addr  out  WIDTH_MEM  cache address
- o_dc_data  out  XLEN  cache write data
- i_dc_ack  in  1  request completes this cycle
- i_dc_data  in  XLEN  read data, valid when i_dc_ack is high
- o_wb_val  out  1  register-file write, single-cycle pulse
- o_wb_rd  out  WIDTH_REG  write destination
- o_wb_tag  out  WIDTH_TAG  write tag
- o_wb_data  out  XLEN  write data
- o_sq_count  out  log2(DEPTH_SQ)+1  occupied entries

## Operation

- **Address.** addr = (i_op1 + i_imm)[WIDTH_MEM-1:0]. The addition wraps modulo 2^WIDTH_MEM.
- **Store queue.** Circular buffer with head, commit and tail pointers. Each entry holds {addr, data, tag, brmask, committed}.
  - Valid entries always occupy head..tail-1. Committed entries are always a prefix of that range.
  - Pointers wrap modulo DEPTH_SQ.
- **Store issue.**
  - Writes an entry at tail with committed = 0.
  - tail and count increment.
  - A store whose i_brmask & i_brkill is nonzero in the issue cycle is not allocated.
- **Commit.**
  - i_commit sets committed on the entry at the commit pointer and clears its brmask.
  - With no uncommitted entry present, i_commit is ignored.
- **Kill.**
  - Every uncommitted entry with brmask & i_brkill != 0 is discarded. These entries form a contiguous youngest suffix, guaranteed by rename.
  - count becomes the survivor count; tail = head + count.
  - Committed entries are never killed.
- **Load issue.** The load searches the SQ for the youngest entry with an equal addr.
  - Hit: forwarded data is written back; no cache access.
  - Miss: the load is captured in a one-entry load buffer {addr, rd, tag, brmask, pending}.
- **o_ready** = !(load buffer pending) & !(count == DEPTH_SQ). This stalls loads too when the queue is full.
- **Cache FSM** has three states:
  - D_IDLE. Priority: pending load → D_LD; else committed head → D_ST; else stay.
  - D_ST drives o_dc_req = 1, o_dc_we = 1, and the head's addr and data. On i_dc_ack: pop head, count--, go to D_IDLE.
  - D_LD drives o_dc_req = 1, o_dc_we = 0, and the buffer addr. On i_dc_ack: write back i_dc_data unless killed, clear pending, go to D_IDLE.
  - Request fields are held stable from entry into D_ST/D_LD until the ack cycle. A request is never abandoned.
- **Load kill.** A load buffer entry whose brmask matches i_brkill is marked dead.
  - In D_IDLE: pending clears immediately.
  - In D_LD: the request completes and the writeback is suppressed.
  - A kill also clears the matching bits of the buffer's brmask.
- **Simultaneous events** in one cycle:
  - Store issue and pop: count unchanged.
  - Commit and kill: the commit applies first.
  - Issue and kill: the issuing op is checked against i_brkill.
  - The forwarding search uses pre-edge SQ contents, including an entry popping that cycle.
- **Reset.**
  - All pointers, counts, pending and valid state, and the FSM (D_IDLE) clear.
  - Outputs reset to: o_ready = 1, all other outputs 0.
  - A reset asserted mid-request drops the request.

## Timing

- Store entry becomes visible to search and o_sq_count the cycle after issue.
- Forwarded load: o_wb_val is high for exactly one cycle, at cycle issue+1.
- Missed load: D_LD is entered at the earliest edge after capture, once the FSM is in D_IDLE. o_wb_val pulses at the cycle after i_dc_ack.
- Minimum miss latency is 2 cycles plus cache latency.
- A committed store is drained at the earliest edge after commit if the FSM is idle. Throughput is one store per 2 cycles with a zero-wait ack.
- o_dc_* are registered FSM outputs. o_wb_* are registered.

## Test plan

- **Store then load, same address.** Store addr 0x10, data 0xDEADBEEF, then load 0x10 → o_wb_val at issue+1, o_wb_data = 0xDEADBEEF, no o_dc_req.
- **Load miss.** Load 0x20 with an empty SQ and ack after 3 cycles returning 0x1234 → o_dc_req=1, o_dc_we=0, addr 0x20 held until ack; o_wb_data = 0x1234; o_ready low while pending.
- **Full and wrap.** Fill with DEPTH_SQ=8 stores → o_ready=0, o_sq_count=8; commit 3 and drain → count 5; issue 3 more → tail wraps to 3 and the data drained later matches issue order.
- **Branch kill.** Issue 4 stores with brmask 0001 (the first 2 committed), then pulse i_brkill=0001 → count=2; the next store lands in slot 2.
- **Kill during D_LD.** Kill the load buffer's branch while in D_LD, then ack → no o_wb_val, FSM returns to D_IDLE, o_ready=1.
- **Mid-drain reset.** Assert i_rst while in D_ST → o_dc_req=0 immediately, o_sq_count=0, o_ready=1.
